// File: rtl/dlx_fetch_queue_pkg.sv
// Shared fetch/decode constants for the uDLX core: reset PC, PC step and
// instruction field widths, so fetch and decode agree on one definition.
package dlx_fetch_queue_pkg;

  localparam int unsigned DLX_INST_ADDR_WIDTH    = 20;
  localparam logic [19:0] DLX_PC_INITIAL_ADDRESS = 20'h40000;
  localparam int unsigned DLX_PC_STEP            = 4;
  localparam int unsigned DLX_OPCODE_WIDTH       = 6;
  localparam int unsigned DLX_FUNCTION_WIDTH     = 6;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dlx_sync_fifo.sv
// Single-clock FIFO with synchronous clear; the head word is exposed directly
// from storage and reads as zero while the FIFO is empty.
module dlx_sync_fifo
  import dlx_fetch_queue_pkg::*;
#(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // NOTE: storage is deliberately not reset; the head is masked while empty,
  // so stale words are never visible and the array maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dlx_fetch_queue.sv
// Instruction fetch stage: issues sequential reads under a credit limit and
// buffers {instruction, pc + step} for decode behind a valid/ready handshake.
module dlx_fetch_queue
  import dlx_fetch_queue_pkg::*;
#(
  parameter int                   DATA_WIDTH         = 32,
  parameter int                   INST_ADDR_WIDTH    = DLX_INST_ADDR_WIDTH,
  parameter logic [INST_ADDR_WIDTH-1:0] PC_INITIAL_ADDRESS = DLX_PC_INITIAL_ADDRESS,
  parameter int                   PC_STEP            = DLX_PC_STEP,
  parameter int                   QUEUE_DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            instr_rd_en,
  output logic [INST_ADDR_WIDTH-1:0]      instr_addr,
  input  logic [DATA_WIDTH-1:0]           instruction,
  input  logic                            select_new_pc_in,
  input  logic [INST_ADDR_WIDTH-1:0]      new_pc_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_instruction,
  output logic [INST_ADDR_WIDTH-1:0]      out_new_pc,
  output logic [$clog2(QUEUE_DEPTH):0]    queue_count
);

  localparam int CW      = count_width(QUEUE_DEPTH);
  localparam int CREDIT_W = CW + 1;
  localparam int ENTRY_W = DATA_WIDTH + INST_ADDR_WIDTH;
  localparam logic [INST_ADDR_WIDTH-1:0] PC_INC = INST_ADDR_WIDTH'(PC_STEP);

  logic [INST_ADDR_WIDTH-1:0] fetch_pc;
  logic [INST_ADDR_WIDTH-1:0] issue_pc;
  logic                       running;
  logic                       inflight;
  logic                       resp_kill;
  logic                       issue;
  logic                       pop;
  logic                       push;
  logic [CREDIT_W-1:0]        credit_used;
  logic [ENTRY_W-1:0]         head_entry;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    pop         = out_valid & out_ready;
    credit_used = {1'b0, queue_count} + CREDIT_W'(inflight) - CREDIT_W'(pop);
    issue       = 1'b0;
    if (running && !select_new_pc_in)
      issue = (credit_used < CREDIT_W'(QUEUE_DEPTH));
    // A response returning in a redirect cycle belongs to the old stream.
    resp_kill   = select_new_pc_in & inflight;
    push        = inflight & ~resp_kill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= PC_INITIAL_ADDRESS;
      issue_pc <= '0;
      running  <= 1'b0;
      inflight <= 1'b0;
    end else begin
      running  <= 1'b1;
      inflight <= issue;
      if (select_new_pc_in) begin
        fetch_pc <= new_pc_in;
      end else if (issue) begin
        fetch_pc <= fetch_pc + PC_INC;
        issue_pc <= fetch_pc;
      end
    end
  end

  dlx_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (select_new_pc_in),
    .push  (push),
    .pop   (pop),
    .din   ({instruction, issue_pc + PC_INC}),
    .dout  (head_entry),
    .count (queue_count)
  );

  assign instr_rd_en                   = issue;
  assign instr_addr                    = fetch_pc;
  assign out_valid                     = (queue_count != '0);
  assign {out_instruction, out_new_pc} = head_entry;

endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Directed bench for dlx_fetch_queue: streaming, stall/fill, redirects,
// PC wrap and mid-stream reset, against an address-tagged instruction memory.
module tb_dlx_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_rd_en;
  logic [19:0] instr_addr;
  logic [31:0] instruction;
  logic        select_new_pc_in;
  logic [19:0] new_pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [19:0] out_new_pc;
  logic [2:0]  queue_count;

  int checks   = 0;
  int failures = 0;

  dlx_fetch_queue #(
    .DATA_WIDTH         (32),
    .INST_ADDR_WIDTH    (20),
    .PC_INITIAL_ADDRESS (20'h40000),
    .PC_STEP            (4),
    .QUEUE_DEPTH        (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_rd_en      (instr_rd_en),
    .instr_addr       (instr_addr),
    .instruction      (instruction),
    .select_new_pc_in (select_new_pc_in),
    .new_pc_in        (new_pc_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_new_pc       (out_new_pc),
    .queue_count      (queue_count)
  );

  always #5 clk = ~clk;

  // Memory returns the address tagged with 0xABC, one cycle after the read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) instruction <= '0;
    else if (instr_rd_en) instruction <= {12'hABC, instr_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic rd, input logic [19:0] addr);
    check({tag, "_rd_en"}, 32'(instr_rd_en), 32'(rd));
    check({tag, "_addr"},  32'(instr_addr),  32'(addr));
  endtask

  // Expected head instruction is derived from the PC: tag of (npc - 4).
  task automatic chk_out(input string tag, input logic valid, input logic [19:0] npc);
    logic [19:0] src;
    src = npc - 20'd4;
    check({tag, "_valid"}, 32'(out_valid), 32'(valid));
    check({tag, "_npc"},   32'(out_new_pc), valid ? 32'(npc) : 32'd0);
    check({tag, "_instr"}, out_instruction, valid ? {12'hABC, src} : 32'd0);
  endtask

  // Queue must never exceed its depth, and out_valid must track occupancy.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("count_bound", 32'(queue_count <= 3'd4), 32'd1);
      check("valid_vs_count", 32'(out_valid), 32'(queue_count != 3'd0));
    end
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; select_new_pc_in = 1'b0; new_pc_in = '0;
    tick(); tick();
    chk_fetch("rst", 1'b0, 20'h40000);
    chk_out("rst", 1'b0, 20'h0);
    check("rst_count", 32'(queue_count), 32'd0);

    rst_n = 1'b1; #1;
    chk_fetch("not_running", 1'b0, 20'h40000);

    // Streaming with out_ready high.
    tick(); chk_fetch("c1", 1'b1, 20'h40000); chk_out("c1", 1'b0, 20'h0);
    tick(); chk_fetch("c2", 1'b1, 20'h40004); chk_out("c2", 1'b0, 20'h0);
    tick(); chk_fetch("c3", 1'b1, 20'h40008); chk_out("c3", 1'b1, 20'h40004);
    check("c3_count", 32'(queue_count), 32'd1);
    tick(); out_ready = 1'b0; #1;
    chk_fetch("c4", 1'b1, 20'h4000C); chk_out("c4", 1'b1, 20'h40008);

    // Stall: queue fills, issue stops once count + inflight reaches 4.
    tick(); chk_fetch("c5", 1'b1, 20'h40010); check("c5_count", 32'(queue_count), 32'd2);
    tick(); chk_fetch("c6", 1'b0, 20'h40014); check("c6_count", 32'(queue_count), 32'd3);
    tick(); chk_fetch("c7", 1'b0, 20'h40014); check("c7_count", 32'(queue_count), 32'd4);
    chk_out("c7", 1'b1, 20'h40008);
    tick(); out_ready = 1'b1; #1;
    chk_fetch("c8", 1'b1, 20'h40014); chk_out("c8", 1'b1, 20'h40008);
    tick(); chk_fetch("c9", 1'b1, 20'h40018); chk_out("c9", 1'b1, 20'h4000C);
    tick(); chk_fetch("c10", 1'b1, 20'h4001C); chk_out("c10", 1'b1, 20'h40010);
    tick(); chk_fetch("c11", 1'b1, 20'h40020); chk_out("c11", 1'b1, 20'h40014);

    // Redirect with 3 queued entries and one read in flight.
    tick(); chk_out("c12", 1'b1, 20'h40018); check("c12_count", 32'(queue_count), 32'd3);
    select_new_pc_in = 1'b1; new_pc_in = 20'h40100; #1;
    chk_fetch("redir", 1'b0, 20'h40024);
    tick(); select_new_pc_in = 1'b0; #1;
    chk_fetch("c13", 1'b1, 20'h40100); chk_out("c13", 1'b0, 20'h0);
    tick(); chk_fetch("c14", 1'b1, 20'h40104); chk_out("c14", 1'b0, 20'h0);
    tick(); chk_out("c15", 1'b1, 20'h40104);

    // Back-to-back redirects: the second target wins.
    select_new_pc_in = 1'b1; new_pc_in = 20'h40200; #1;
    check("c15_rd_en", 32'(instr_rd_en), 32'd0);
    tick(); new_pc_in = 20'h40300; #1;
    check("c16_rd_en", 32'(instr_rd_en), 32'd0); chk_out("c16", 1'b0, 20'h0);
    tick(); select_new_pc_in = 1'b0; #1;
    chk_fetch("c17", 1'b1, 20'h40300); chk_out("c17", 1'b0, 20'h0);
    tick(); chk_fetch("c18", 1'b1, 20'h40304); chk_out("c18", 1'b0, 20'h0);
    tick(); chk_out("c19", 1'b1, 20'h40304);

    // PC wrap at the top of the 20-bit range.
    select_new_pc_in = 1'b1; new_pc_in = 20'hFFFF8; #1;
    tick(); select_new_pc_in = 1'b0; #1;
    chk_fetch("c20", 1'b1, 20'hFFFF8);
    tick(); chk_fetch("c21", 1'b1, 20'hFFFFC);
    tick(); chk_fetch("c22", 1'b1, 20'h00000); chk_out("c22", 1'b1, 20'hFFFFC);
    tick(); chk_fetch("c23", 1'b1, 20'h00004); chk_out("c23", 1'b1, 20'h00000);
    tick(); chk_out("c24", 1'b1, 20'h00004);

    // Fill the queue, then reset mid-stream.
    out_ready = 1'b0; #1;
    chk_fetch("c24", 1'b1, 20'h00008);
    tick(); tick(); tick();
    check("full_count", 32'(queue_count), 32'd4);
    rst_n = 1'b0; #1;
    chk_fetch("mid_rst", 1'b0, 20'h40000);
    chk_out("mid_rst", 1'b0, 20'h0);
    check("mid_rst_count", 32'(queue_count), 32'd0);
    tick(); tick();
    out_ready = 1'b1; rst_n = 1'b1; #1;
    tick(); chk_fetch("r1", 1'b1, 20'h40000);
    tick(); chk_fetch("r2", 1'b1, 20'h40004);
    tick(); chk_out("r3", 1'b1, 20'h40004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
